// File: rtl/simon_pkg.sv
// Shared types and constants for the memory-game sequencer.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHOW_ON,
    SHOW_GAP,
    WAIT_INPUT,
    FAILED,
    DONE
  } state_e;

  typedef logic [1:0] color_t;

  localparam color_t RED    = 2'd0;
  localparam color_t GREEN  = 2'd1;
  localparam color_t BLUE   = 2'd2;
  localparam color_t YELLOW = 2'd3;

  localparam int unsigned STAGE_W = 3;
  localparam int unsigned BTN_W   = 4;

  // Counter width for a value range; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/simon_sequencer_if.sv
// Button/LED/status bundle between the game controller and its surroundings.
interface simon_sequencer_if;
  import simon_pkg::*;

  logic               start;
  color_t             rand_in;
  logic [BTN_W-1:0]   button_in;
  logic               led_on;
  color_t             led_color;
  logic [STAGE_W-1:0] stage_level;
  logic               stage_clear;
  logic               fail;
  logic               all_clear;
  logic               busy;

  // Environment side: supplies start, randomness and presses.
  modport master (
    output start, rand_in, button_in,
    input  led_on, led_color, stage_level, stage_clear, fail, all_clear, busy
  );

  // Controller side.
  modport slave (
    input  start, rand_in, button_in,
    output led_on, led_color, stage_level, stage_clear, fail, all_clear, busy
  );

endinterface

// File: rtl/simon_phase_timer.sv
// Loadable saturating down-counter; done_c_o is high while the count is zero.
module simon_phase_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_c_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Reload on request, otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c_o = (cnt_q == '0);

endmodule

// File: rtl/simon_sequencer.sv
// Memory-game flow controller: stores the pattern, plays it back, judges presses.
// Optional input timeout in WAIT_INPUT is built when SIMON_TIMEOUT_EN is defined.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 5,
  parameter int unsigned SHOW_CYCLES    = 50_000_000,
  parameter int unsigned GAP_CYCLES     = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic             clock,
  input  logic             reset,
  simon_sequencer_if.slave bus
);

`ifdef SIMON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int unsigned IDX_W   = clog2_min1(NUM_STAGES);
  localparam int unsigned MAX_CYC = max3(SHOW_CYCLES, GAP_CYCLES, TO_EN ? TIMEOUT_CYCLES : 1);
  localparam int unsigned TMR_W   = clog2_min1(MAX_CYC);

  localparam logic [TMR_W-1:0] SHOW_LOAD = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               led_on_q, led_on_d;
  color_t             led_color_q, led_color_d;
  logic               stage_clear_q, stage_clear_d;
  logic               fail_q, fail_d;
  logic               all_clear_q, all_clear_d;
  logic               busy_q, busy_d;

  color_t             pattern_q [NUM_STAGES];
  logic               pat_we;
  logic [IDX_W-1:0]   pat_waddr;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_done_c;

  logic [IDX_W-1:0]   idx_nxt;
  logic               idx_last;
  logic               press_ok;

  assign idx_nxt  = idx_q + IDX_W'(1);
  assign idx_last = (idx_q == IDX_W'(stage_q - STAGE_W'(1)));
  // Exactly the one bit matching the stored colour; multi-hot never matches.
  assign press_ok = (bus.button_in == (BTN_W'(1) << pattern_q[idx_q]));

  simon_phase_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_c_o   (tmr_done_c)
  );

  // Next-state, pattern write, timer control and next output values.
  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    idx_d         = idx_q;
    led_on_d      = 1'b0;
    led_color_d   = RED;
    stage_clear_d = 1'b0;
    fail_d        = 1'b0;
    pat_we        = 1'b0;
    pat_waddr     = '0;
    tmr_load      = 1'b0;
    tmr_val       = SHOW_LOAD;

    case (state_q)
      IDLE, FAILED, DONE: begin
        // Red fail indication stays on until the timer runs out.
        if (state_q == FAILED) begin
          led_on_d = led_on_q & ~tmr_done_c;
        end
        if (bus.start) begin
          pat_we      = 1'b1;
          pat_waddr   = '0;
          stage_d     = STAGE_W'(1);
          idx_d       = '0;
          state_d     = SHOW_ON;
          tmr_load    = 1'b1;
          tmr_val     = SHOW_LOAD;
          led_on_d    = 1'b1;
          led_color_d = bus.rand_in;
        end
      end

      SHOW_ON: begin
        led_on_d    = 1'b1;
        led_color_d = led_color_q;
        if (tmr_done_c) begin
          state_d     = SHOW_GAP;
          led_on_d    = 1'b0;
          led_color_d = RED;
          tmr_load    = 1'b1;
          tmr_val     = GAP_LOAD;
        end
      end

      SHOW_GAP: begin
        if (tmr_done_c) begin
          tmr_load = 1'b1;
          if (idx_last) begin
            idx_d   = '0;
            state_d = WAIT_INPUT;
            tmr_val = WAIT_LOAD;
          end else begin
            idx_d       = idx_nxt;
            state_d     = SHOW_ON;
            tmr_val     = SHOW_LOAD;
            led_on_d    = 1'b1;
            led_color_d = pattern_q[idx_nxt];
          end
        end
      end

      WAIT_INPUT: begin
        if (bus.button_in != '0) begin
          if (!press_ok) begin
            fail_d   = 1'b1;
            state_d  = FAILED;
            tmr_load = 1'b1;
            tmr_val  = SHOW_LOAD;
            led_on_d = 1'b1;
          end else if (!idx_last) begin
            idx_d    = idx_nxt;
            tmr_load = 1'b1;
            tmr_val  = WAIT_LOAD;
          end else begin
            stage_clear_d = 1'b1;
            if (stage_q == STAGE_W'(NUM_STAGES)) begin
              state_d = DONE;
            end else begin
              pat_we      = 1'b1;
              pat_waddr   = IDX_W'(stage_q);
              stage_d     = stage_q + STAGE_W'(1);
              idx_d       = '0;
              state_d     = SHOW_ON;
              tmr_load    = 1'b1;
              tmr_val     = SHOW_LOAD;
              led_on_d    = 1'b1;
              led_color_d = pattern_q[0];
            end
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (tmr_done_c) begin
          fail_d   = 1'b1;
          state_d  = FAILED;
          tmr_load = 1'b1;
          tmr_val  = SHOW_LOAD;
          led_on_d = 1'b1;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    all_clear_d = (state_d == DONE);
    busy_d      = !(state_d inside {IDLE, FAILED, DONE});
  end

  // Control state and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      stage_q       <= '0;
      idx_q         <= '0;
      led_on_q      <= 1'b0;
      led_color_q   <= RED;
      stage_clear_q <= 1'b0;
      fail_q        <= 1'b0;
      all_clear_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      idx_q         <= idx_d;
      led_on_q      <= led_on_d;
      led_color_q   <= led_color_d;
      stage_clear_q <= stage_clear_d;
      fail_q        <= fail_d;
      all_clear_q   <= all_clear_d;
      busy_q        <= busy_d;
    end
  end

  // Pattern storage; contents after reset are don't-care.
  always_ff @(posedge clock) begin
    if (pat_we) begin
      pattern_q[pat_waddr] <= bus.rand_in;
    end
  end

  assign bus.led_on      = led_on_q;
  assign bus.led_color   = led_color_q;
  assign bus.stage_level = stage_q;
  assign bus.stage_clear = stage_clear_q;
  assign bus.fail        = fail_q;
  assign bus.all_clear   = all_clear_q;
  assign bus.busy        = busy_q;

endmodule
